// File: rtl/jtframe_dump_pkg.sv
// Shared definitions for the frame-windowed dump controller: mode encoding and
// per-channel state type.
package jtframe_dump_pkg;

  localparam logic [1:0] DUMP_OFF    = 2'd0;
  localparam logic [1:0] DUMP_ALWAYS = 2'd1;
  localparam logic [1:0] DUMP_FRAME  = 2'd2;
  localparam logic [1:0] DUMP_DWNLD  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StOn,
    StDone
  } chan_st_t;

endpackage

// File: rtl/jtframe_dump_chan.sv
// One dump channel: arms in WAIT, dumps in ON for len frames (0 = forever),
// re-armed by every download start.
module jtframe_dump_chan
  import jtframe_dump_pkg::*;
#(
  parameter int unsigned FW = 32,
  parameter int unsigned LW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic [FW-1:0] start,
  input  logic [LW-1:0] len,
  input  logic [FW-1:0] frame_cnt,
  input  logic          vs_fall,
  input  logic          dwnld,
  input  logic          dwnld_rise,
  input  logic          dwnld_fall,
  output logic          dump_on,
  output logic          dump_start,
  output logic          dump_stop
);

  chan_st_t      st;
  logic [LW-1:0] cnt;
  logic [LW-1:0] cnt_inc;
  logic          arm_hit;

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    arm_hit = 1'b0;
    unique case (mode)
      DUMP_OFF:    arm_hit = 1'b0;
      DUMP_ALWAYS: arm_hit = !dwnld;
      DUMP_FRAME:  arm_hit = !dwnld && (frame_cnt == start);
      DUMP_DWNLD:  arm_hit = dwnld_fall;
      default:     arm_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= StWait;
      cnt        <= '0;
      dump_on    <= 1'b0;
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
    end else begin
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
      if (dwnld_rise) begin
        // re-arm overrides whatever the channel was about to do
        st <= StWait;
        if (st == StOn) begin
          dump_on   <= 1'b0;
          dump_stop <= 1'b1;
        end
      end else begin
        unique case (st)
          StWait: begin
            if (mode == DUMP_OFF) begin
              st <= StIdle;
            end else if (arm_hit) begin
              st         <= StOn;
              cnt        <= '0;
              dump_on    <= 1'b1;
              dump_start <= 1'b1;
            end
          end
          StOn: begin
            if (vs_fall) begin
              cnt <= cnt_inc;
              if (len != '0 && cnt_inc == len) begin
                st        <= StDone;
                dump_on   <= 1'b0;
                dump_stop <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/jtframe_dump_ctrl.sv
// Frame-windowed dump trigger: vs synchroniser, frame counter, download edge
// detection and CH independent dump channels.
module jtframe_dump_ctrl #(
  parameter int unsigned CH = 4,
  parameter int unsigned FW = 32,
  parameter int unsigned LW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vs,
  input  logic             dwnld,
  input  logic [2*CH-1:0]  mode,
  input  logic [FW*CH-1:0] start,
  input  logic [LW*CH-1:0] len,
  output logic [FW-1:0]    frame_cnt,
  output logic [CH-1:0]    dump_on,
  output logic [CH-1:0]    dump_start,
  output logic [CH-1:0]    dump_stop
);

  logic vs_s1, vs_s2, vs_s3;
  logic vs_fall;
  logic dwnld_q;
  logic dwnld_rise, dwnld_fall;

  assign dwnld_rise = dwnld && !dwnld_q;
  assign dwnld_fall = !dwnld && dwnld_q;

  // vs is asynchronous: two sync stages, then a registered falling-edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_s1   <= 1'b0;
      vs_s2   <= 1'b0;
      vs_s3   <= 1'b0;
      vs_fall <= 1'b0;
      dwnld_q <= 1'b0;
    end else begin
      vs_s1   <= vs;
      vs_s2   <= vs_s1;
      vs_s3   <= vs_s2;
      vs_fall <= vs_s3 && !vs_s2;
      dwnld_q <= dwnld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (dwnld) begin
      frame_cnt <= '0;
    end else if (vs_fall) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_chan
    jtframe_dump_chan #(
      .FW(FW),
      .LW(LW)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (mode[2*k+:2]),
      .start      (start[FW*k+:FW]),
      .len        (len[LW*k+:LW]),
      .frame_cnt  (frame_cnt),
      .vs_fall    (vs_fall),
      .dwnld      (dwnld),
      .dwnld_rise (dwnld_rise),
      .dwnld_fall (dwnld_fall),
      .dump_on    (dump_on[k]),
      .dump_start (dump_start[k]),
      .dump_stop  (dump_stop[k])
    );
  end

endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
// Scoreboard bench for jtframe_dump_ctrl: expected start/stop events are
// derived per round from frame numbers and checked as the DUT pulses.
module tb_jtframe_dump_ctrl;

  localparam int CH = 2;
  localparam int FW = 4;
  localparam int LW = 8;
  localparam int WRAP = 1 << FW;

  typedef struct {
    bit stop;
    int fc;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             vs = 1'b1;
  logic             dwnld = 1'b0;
  logic [2*CH-1:0]  mode = '0;
  logic [FW*CH-1:0] start = '0;
  logic [LW*CH-1:0] len = '0;
  logic [FW-1:0]    frame_cnt;
  logic [CH-1:0]    dump_on, dump_start, dump_stop;

  int  checks = 0;
  int  errors = 0;
  ev_t evq[CH][$];
  bit  on_end[CH];

  always #5 clk = ~clk;

  jtframe_dump_ctrl #(
    .CH(CH),
    .FW(FW),
    .LW(LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vs         (vs),
    .dwnld      (dwnld),
    .mode       (mode),
    .start      (start),
    .len        (len),
    .frame_cnt  (frame_cnt),
    .dump_on    (dump_on),
    .dump_start (dump_start),
    .dump_stop  (dump_stop)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic ncyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int hi, input int lo);
    vs = 1'b0;
    ncyc(lo);
    vs = 1'b1;
    ncyc(hi);
  endtask

  task automatic push_ev(input int k, input bit stop, input int fc);
    ev_t e;
    e.stop = stop;
    e.fc   = fc % WRAP;
    evq[k].push_back(e);
  endtask

  // Pops the expected event whenever a channel pulses dump_start/dump_stop
  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < CH; k++) begin
        if (dump_start[k] || dump_stop[k]) begin
          if (evq[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse ch%0d: got start=%0b stop=%0b expected none (t=%0t)",
                     k, dump_start[k], dump_stop[k], $time);
          end else begin
            e = evq[k].pop_front();
            chk($sformatf("pulse_start_ch%0d", k), int'(dump_start[k]), int'(!e.stop));
            chk($sformatf("pulse_stop_ch%0d", k), int'(dump_stop[k]), int'(e.stop));
            chk($sformatf("pulse_fc_ch%0d", k), int'(frame_cnt), e.fc);
            chk($sformatf("pulse_on_ch%0d", k), int'(dump_on[k]), int'(!e.stop));
          end
        end
      end
    end
  endtask

  // One download followed by F frames; expectations from frame numbers since download end
  task automatic round(input int m0, input int s0, input int l0,
                       input int m1, input int s1, input int l1, input int nf);
    int m[CH], s[CH], l[CH], entry;
    m[0] = m0; s[0] = s0; l[0] = l0;
    m[1] = m1; s[1] = s1; l[1] = l1;
    for (int k = 0; k < CH; k++) begin
      if (on_end[k]) push_ev(k, 1'b1, 0);
      mode[2*k+:2]   = 2'(m[k]);
      start[FW*k+:FW] = FW'(s[k]);
      len[LW*k+:LW]   = LW'(l[k]);
    end
    dwnld = 1'b1;
    ncyc(50);
    chk("fc_during_dwnld", int'(frame_cnt), 0);
    for (int k = 0; k < CH; k++) begin
      on_end[k] = 1'b0;
      if (m[k] != 0) begin
        entry = (m[k] == 2) ? s[k] : 0;
        if (entry <= nf) begin
          push_ev(k, 1'b0, entry);
          if (l[k] != 0 && entry + l[k] <= nf) push_ev(k, 1'b1, entry + l[k]);
          else on_end[k] = 1'b1;
        end
      end
    end
    dwnld = 1'b0;
    ncyc(20);
    repeat (nf) frame(32, 8);
    chk("fc_after_frames", int'(frame_cnt), nf % WRAP);
    for (int k = 0; k < CH; k++) begin
      chk($sformatf("pending_ch%0d", k), evq[k].size(), 0);
      chk($sformatf("dump_on_end_ch%0d", k), int'(dump_on[k]), int'(on_end[k]));
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Out of reset: ch0 always, ch1 frame window at start=0, both unlimited
    mode = {2'd2, 2'd1};
    #1;
    chk("reset_fc", int'(frame_cnt), 0);
    chk("reset_on", int'(dump_on), 0);
    chk("reset_start", int'(dump_start), 0);
    chk("reset_stop", int'(dump_stop), 0);
    push_ev(0, 1'b0, 0);
    push_ev(1, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("on_after_release", int'(dump_on), 3);
    repeat (1000) frame(12, 8);
    chk("unlimited_on", int'(dump_on), 3);
    chk("unlimited_fc", int'(frame_cnt), 1000 % WRAP);
    on_end[0] = 1'b1;
    on_end[1] = 1'b1;

    round(2, 5, 3, 0, 0, 0, 12);  // frame window, idle neighbour
    round(3, 0, 2, 1, 0, 4, 8);   // after download / always with length
    round(2, 1, 0, 2, 2, 0, 20);  // unlimited windows across a wrap
    round(2, 1, 0, 2, 2, 0, 6);   // re-arm while ON
    for (int i = 0; i < 10; i++) begin
      round($urandom_range(0, 3), $urandom_range(0, WRAP - 1), $urandom_range(0, 12),
            $urandom_range(0, 3), $urandom_range(0, WRAP - 1), $urandom_range(0, 12),
            $urandom_range(4, 30));
    end

    // Asynchronous reset mid-window: immediate clear and no stop pulse afterwards
    round(1, 0, 0, 2, 1, 5, 3);
    for (int k = 0; k < CH; k++) begin
      evq[k].delete();
      on_end[k] = 1'b0;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_on", int'(dump_on), 0);
    chk("async_rst_fc", int'(frame_cnt), 0);
    chk("async_rst_pulses", int'({dump_start, dump_stop}), 0);
    mode = '0;
    ncyc(5);
    rst_n = 1'b1;
    ncyc(20);
    chk("post_rst_on", int'(dump_on), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
